// File: rtl/nco_pkg.sv
// Shared definitions for the NCO capture block: lane count, default sample
// width and the controller state encoding.
// Optional feature macro: NCO_CAP_TRIGGER_EN (adds the ARM state).
package nco_pkg;

  localparam int unsigned LANES      = 3;
  localparam int unsigned DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
`ifdef NCO_CAP_TRIGGER_EN
    ,
    ST_ARM     = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/nco_cap_ram.sv
// Capture storage: simple dual-port RAM, one full triplet ({cos, sin}) per
// word, registered read data that holds until the next read.
module nco_cap_ram #(
  parameter int unsigned W     = 96,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // read port, one cycle latency
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/nco_capture.sv
// Captures DEPTH polyphase sin/cos triplets from a non-stallable source and
// replays them as single {cos, sin} samples on an AXI-stream master.
// Optional feature macro: NCO_CAP_TRIGGER_EN (arm on a sin zero crossing
// from negative to non-negative before capturing).
module nco_capture
  import nco_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned DEPTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [LANES*DW-1:0] in_sin,
  input  logic [LANES*DW-1:0] in_cos,
  output logic [2*DW-1:0]     m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic                busy,
  output logic                done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = LANES * 2 * DW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]      lane_q, lane_d;
  logic            src_ok_q, src_ok_d;
  logic [2*DW-1:0] tdata_d;
  logic            tvalid_d, tlast_d, busy_d, done_d;

  logic            ram_we, ram_re;
  logic [AW-1:0]   ram_waddr, ram_raddr;
  logic [RW-1:0]   ram_rdata;
  logic [RW-1:0]   ram_wdata;
  logic            crossing;

  assign ram_wdata = {in_cos, in_sin};

  // Pick one lane of a packed triplet.
  function automatic logic [DW-1:0] lane_of(input logic [LANES*DW-1:0] v,
                                            input logic [1:0] k);
    case (k)
      2'd1:    return v[DW +: DW];
      2'd2:    return v[2*DW +: DW];
      default: return v[0 +: DW];
    endcase
  endfunction

`ifdef NCO_CAP_TRIGGER_EN
  logic prev_neg_q;

  // Sign of the last valid lane2 sin sample, seeds the crossing search.
  always_ff @(posedge clk) begin
    if (rst) prev_neg_q <= 1'b0;
    else if (in_valid) prev_neg_q <= in_sin[LANES*DW-1];
  end

  // Negative to non-negative transition across prev lane2, lane0, lane1, lane2.
  always_comb begin
    logic [3:0] neg;
    neg = {in_sin[3*DW-1], in_sin[2*DW-1], in_sin[DW-1], prev_neg_q};
    crossing = (neg[0] & ~neg[1]) | (neg[1] & ~neg[2]) | (neg[2] & ~neg[3]);
  end
`else
  assign crossing = 1'b0;
`endif

  nco_cap_ram #(
    .W     (RW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  // Next-state, counter and output logic; the RAM output register holds the
  // current entry and the next entry is fetched as its lane2 is loaded.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_ptr_d  = rd_ptr_q;
    lane_d    = lane_q;
    src_ok_d  = src_ok_q;
    tdata_d   = m_tdata;
    tvalid_d  = m_tvalid;
    tlast_d   = m_tlast;
    done_d    = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = wr_addr_q;
    ram_re    = 1'b0;
    ram_raddr = rd_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          wr_addr_d = '0;
`ifdef NCO_CAP_TRIGGER_EN
          state_d   = ST_ARM;
`else
          state_d   = ST_CAPTURE;
`endif
        end
      end
`ifdef NCO_CAP_TRIGGER_EN
      ST_ARM: begin
        if (in_valid && crossing) begin
          ram_we    = 1'b1;
          ram_waddr = '0;
          wr_addr_d = AW'(1);
          state_d   = ST_CAPTURE;
        end
      end
`endif
      ST_CAPTURE: begin
        if (in_valid) begin
          ram_we = 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            wr_addr_d = '0;
            ram_re    = 1'b1;
            ram_raddr = '0;
            rd_ptr_d  = '0;
            lane_d    = 2'd0;
            src_ok_d  = 1'b1;
            state_d   = ST_DRAIN;
          end else begin
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (m_tvalid && m_tready && m_tlast) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (src_ok_q && (!m_tvalid || m_tready)) begin
          tvalid_d = 1'b1;
          tdata_d  = {lane_of(ram_rdata[RW-1 -: LANES*DW], lane_q),
                      lane_of(ram_rdata[LANES*DW-1:0], lane_q)};
          tlast_d  = (rd_ptr_q == LAST_ADDR) && (lane_q == 2'd2);
          if (lane_q == 2'd2) begin
            lane_d = 2'd0;
            if (rd_ptr_q == LAST_ADDR) begin
              src_ok_d = 1'b0;
            end else begin
              rd_ptr_d  = rd_ptr_q + AW'(1);
              ram_re    = 1'b1;
              ram_raddr = rd_ptr_q + AW'(1);
            end
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end else if (m_tvalid && m_tready) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs; rst aborts everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_addr_q <= '0;
      rd_ptr_q  <= '0;
      lane_q    <= 2'd0;
      src_ok_q  <= 1'b0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_ptr_q  <= rd_ptr_d;
      lane_q    <= lane_d;
      src_ok_q  <= src_ok_d;
      m_tdata   <= tdata_d;
      m_tvalid  <= tvalid_d;
      m_tlast   <= tlast_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_nco_capture.sv
// Scoreboard bench for nco_capture: stimulus pushes expected beats, an
// independent negedge monitor pops and compares every completed beat.
module tb_nco_capture;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NB    = 3 * DEPTH;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic [3*DW-1:0] in_sin = '0;
  logic [3*DW-1:0] in_cos = '0;
  logic [2*DW-1:0] m_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b0;
  logic            m_tlast;
  logic            busy;
  logic            done;

  int total = 0;
  int bad = 0;
  int beats = 0;
  int done_cnt = 0;
  logic [2*DW:0] exp_q[$];
  bit rand_ready = 1'b0;
  bit ready_off = 1'b0;
  bit stall_prev = 1'b0;
  logic [2*DW:0] held = '0;

  always #5 clk = ~clk;

  nco_capture #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_sin   (in_sin),
    .in_cos   (in_cos),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink ready: fixed high, random, or forced low.
  always @(posedge clk) begin
    #3;
    m_tready = ready_off ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Monitor: beat scoreboard, stall stability and done counting.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        check("stall_valid", 64'(m_tvalid), 64'(1));
        check("stall_data", 64'({m_tlast, m_tdata}), 64'(held));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got %0h expected no beat", {m_tlast, m_tdata});
        end else begin
          check("beat", 64'({m_tlast, m_tdata}), 64'(exp_q.pop_front()));
        end
        beats++;
      end
      if (done) done_cnt++;
    end
    stall_prev = m_tvalid && !m_tready && !rst;
    held = {m_tlast, m_tdata};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s0, input int s1, input int s2, input bit v);
    in_valid = v;
    in_sin   = {16'(s2), 16'(s1), 16'(s0)};
    in_cos   = {16'(-s2), 16'(-s1), 16'(-s0)};
    tick();
  endtask

  task automatic expect_entry(input int idx, input int s0, input int s1, input int s2);
    int s[3];
    s = '{s0, s1, s2};
    for (int k = 0; k < 3; k++)
      exp_q.push_back({1'(idx == DEPTH - 1 && k == 2), 16'(-s[k]), 16'(s[k])});
  endtask

  // Start pulse with a junk valid triplet in the same cycle (must not be kept).
  task automatic do_start(input string name);
    start = 1'b1;
    drive(900, 901, 902, 1'b1);
    start = 1'b0;
    check({name, "_busy_after_start"}, 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input string name, input int d0, input int b0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_busy_idle"}, 64'(busy), 64'(0));
    repeat (4) tick();
    check({name, "_done_pulses"}, 64'(done_cnt), 64'(d0 + 1));
    check({name, "_beat_count"}, 64'(beats - b0), 64'(NB));
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats < target && n < 400) begin
      @(posedge clk);
      n++;
    end
  endtask

  initial begin
    int d0, b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_tlast", 64'(m_tlast), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_tdata", 64'(m_tdata), 64'(0));
    tick();

`ifdef NCO_CAP_TRIGGER_EN
    // Trigger: prior lane2 = -5, crossing triplet (-3, 2, 7) becomes entry 0.
    d0 = done_cnt; b0 = beats;
    do_start("trig");
    drive(-10, -8, -5, 1'b1);
    expect_entry(0, -3, 2, 7);
    drive(-3, 2, 7, 1'b1);
    for (int i = 1; i < DEPTH; i++) begin
      expect_entry(i, 3*i, 3*i + 1, 3*i + 2);
      drive(3*i, 3*i + 1, 3*i + 2, 1'b1);
    end
    in_valid = 1'b0;
    wait_done("trig", d0, b0);
`else
    // Basic capture with ready held high.
    d0 = done_cnt; b0 = beats;
    do_start("basic");
    for (int i = 0; i < DEPTH; i++) begin
      expect_entry(i, 3*i, 3*i + 1, 3*i + 2);
      drive(3*i, 3*i + 1, 3*i + 2, 1'b1);
    end
    in_valid = 1'b0;
    wait_done("basic", d0, b0);

    // Backpressure: random ready, same beat sequence.
    rand_ready = 1'b1;
    d0 = done_cnt; b0 = beats;
    do_start("bp");
    for (int i = 0; i < DEPTH; i++) begin
      expect_entry(i, 3*i, 3*i + 1, 3*i + 2);
      drive(3*i, 3*i + 1, 3*i + 2, 1'b1);
    end
    in_valid = 1'b0;
    wait_done("bp", d0, b0);
    rand_ready = 1'b0;

    // Gapped input: junk on in_valid=0 cycles must be skipped.
    d0 = done_cnt; b0 = beats;
    do_start("gap");
    for (int i = 0; i < DEPTH; i++) begin
      drive(600 + i, 700 + i, 800 + i, 1'b0);
      expect_entry(i, 100 + 3*i, 101 + 3*i, 102 + 3*i);
      drive(100 + 3*i, 101 + 3*i, 102 + 3*i, 1'b1);
    end
    in_valid = 1'b0;
    wait_done("gap", d0, b0);

    // Start pulses during CAPTURE and DRAIN are ignored.
    d0 = done_cnt; b0 = beats;
    do_start("ign");
    for (int i = 0; i < DEPTH; i++) begin
      start = (i == 2);
      expect_entry(i, 40 + 3*i, 41 + 3*i, 42 + 3*i);
      drive(40 + 3*i, 41 + 3*i, 42 + 3*i, 1'b1);
    end
    start = 1'b0;
    in_valid = 1'b0;
    wait_beats(b0 + 3);
    #1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign", d0, b0);

    // Reset right after beat 5 completes: no more beats and no done.
    d0 = done_cnt; b0 = beats;
    do_start("rstd");
    for (int i = 0; i < DEPTH; i++) begin
      expect_entry(i, 3*i, 3*i + 1, 3*i + 2);
      drive(3*i, 3*i + 1, 3*i + 2, 1'b1);
    end
    in_valid = 1'b0;
    wait_beats(b0 + 6);
    #1;
    rst = 1'b1;
    ready_off = 1'b1;
    tick();
    rst = 1'b0;
    check("rstd_tvalid", 64'(m_tvalid), 64'(0));
    check("rstd_busy", 64'(busy), 64'(0));
    check("rstd_done", 64'(done), 64'(0));
    check("rstd_tdata", 64'(m_tdata), 64'(0));
    exp_q.delete();
    ready_off = 1'b0;
    repeat (10) tick();
    check("rstd_no_done", 64'(done_cnt), 64'(d0));
    check("rstd_beats", 64'(beats - b0), 64'(6));
    check("rstd_idle_valid", 64'(m_tvalid), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nco_capture.md
NCO_CAPTURE -- requirements
Module: nco_capture

Interface
REQ-001 SHALL have parameter DW, default 16, width of one sin or cos sample.
REQ-002 SHALL have parameter DEPTH, default 64, number of captured 3-lane triplets; power of 2, at least 4.
REQ-003 SHALL have port clk, input, 1, clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port start, input, 1, single-cycle capture request.
REQ-006 SHALL have port in_valid, input, 1, upstream triplet valid; the source cannot be stalled.
REQ-007 SHALL have port in_sin, input, 3*DW, polyphase sin triplet; lane k at [k*DW +: DW]; lane0 is the earliest sample.
REQ-008 SHALL have port in_cos, input, 3*DW, polyphase cos triplet; same lane packing as in_sin.
REQ-009 SHALL have port m_tdata, output, 2*DW, one sample per beat as {cos, sin}.
REQ-010 SHALL have ports m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1), forming an AXI-stream master.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse.

Function
REQ-013 SHALL implement the states IDLE, CAPTURE and DRAIN, plus ARM when the trigger is compiled in.
REQ-014 SHALL, in IDLE, move to CAPTURE on start=1; start in any other state is ignored.
REQ-015 SHALL, in CAPTURE, write each in_valid=1 triplet to consecutive addresses 0..DEPTH-1, starting with the first in_valid cycle after the start cycle.
REQ-016 SHALL skip in_valid=0 cycles without writing and move to DRAIN the cycle after write DEPTH-1.
REQ-017 SHALL, in DRAIN, emit 3*DEPTH beats in the order entry0 lane0, entry0 lane1, entry0 lane2, entry1 lane0, and so on.
REQ-018 SHALL assert m_tvalid no later than 2 cycles after entering DRAIN.
REQ-019 SHALL complete a beat only when m_tvalid and m_tready are both high.
REQ-020 SHALL hold m_tdata and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-021 SHALL, once the first beat is presented, sustain one beat per cycle while m_tready is held high, with no bubbles.
REQ-022 SHALL assert m_tlast only on beat 3*DEPTH-1.
REQ-023 SHALL pulse done and return to IDLE in the cycle after the m_tlast beat completes.
REQ-024 SHALL drop in_valid triplets during DRAIN and IDLE; there is no overflow condition.
REQ-025 SHALL use counter widths of $clog2(DEPTH) bits for the address and 2 bits for the lane, with the lane wrapping 2 to 0 and incrementing the address.
REQ-026 SHALL accept a new start in IDLE in the same cycle done is high.

Reset
REQ-027 SHALL, on rst=1, enter IDLE and clear all counters.
REQ-028 SHALL drive m_tvalid=0, m_tlast=0, busy=0, done=0 and m_tdata=0 in the cycle after rst.
REQ-029 SHALL abort any capture or drain on rst without emitting further beats; RAM contents are don't-care.

Configuration
REQ-030 SHALL, with NCO_CAP_TRIGGER_EN defined, make start go to ARM instead of CAPTURE.
REQ-031 SHALL leave ARM on the first in_valid triplet that contains a sin sign change from negative to non-negative in the sequence (previous valid lane2, lane0, lane1, lane2).
REQ-032 SHALL write that crossing triplet as entry 0 and enter CAPTURE to continue from entry 1.
REQ-033 SHALL have no ARM state and no comparison logic when NCO_CAP_TRIGGER_EN is undefined.

Structure
REQ-034 SHALL place the state enum, LANES=3 and the default DW in a shared package nco_pkg.
REQ-035 SHALL implement storage in one sub-module nco_cap_ram: simple dual-port, 3*2*DW wide, DEPTH deep, synchronous 1-cycle read.

Verification
REQ-036 SHALL cover basic capture: DEPTH=4, in_valid=1, in_sin lane values = 3n+k and cos = -(3n+k) -> 12 beats, sin 0..11 in order, m_tlast on beat 11, done pulsed once.
REQ-037 SHALL cover backpressure: m_tready random at 50% -> identical beat sequence, m_tdata stable on every stalled cycle.
REQ-038 SHALL cover gapped input: in_valid toggling 1/0 -> only the valid triplets are captured, in order, with no duplicates.
REQ-039 SHALL cover reset mid-drain: rst after beat 5 -> m_tvalid=0 the next cycle, busy=0, and no done pulse.
REQ-040 SHALL cover ignored start: start pulsed during CAPTURE and during DRAIN -> no restart and exactly 3*DEPTH beats.
REQ-041 SHALL cover the trigger (NCO_CAP_TRIGGER_EN): prior lane2 = -5, triplet (-3, 2, 7) -> that triplet is entry 0 and the first beat sin is -3.
